matrix_scan_ctrl: RTL and testbench
===================================

# matrix_scan_ctrl

Scan controller for the 5-row × 7-column LED dot-matrix display. It time-multiplexes the columns with an active-low one-hot strobe and inserts a one-cycle anti-ghosting blank per column. For each column it drives the 5 row bits from a 4-message, 16-column pattern ROM selected by the ch1/ch0 switches. It scrolls a 7-column window across the selected message, and it replaces the separate counter/shift-register chain with a single sequenced block.

## Interface
- CLK_DIV, 50000, clk cycles per column period; must be ≥ 2
- SCROLL_FRAMES, 32, frames per one-column scroll step; must be ≥ 1
- clk  in  1  system clock; single clock domain
- rst_n  in  1  asynchronous, active-low reset
- ch1, ch0  in  1 each  message select {ch1,ch0}; asynchronous switches
- scroll_en  in  1  enables window scrolling; synchronous level
- acender_coluna  out  7  column strobe, active-low one-hot; column 0 = bit 6
- linhas  out  5  row data, active-high; bit 0 = top row
- frame_start  out  1  one-cycle pulse in the first DRIVE cycle of column 0
- msg_ativa  out  2  currently displayed message index

## Operation
- Prescaler `pre` counts 0..CLK_DIV-1 and wraps. Column index `col` (0..6) advances on the edge where `pre` wraps; col 6→0 is the frame boundary.
- State is derived from `pre`: BLANK when pre==0, DRIVE otherwise.
- In BLANK: acender_coluna=7'h7F, linhas=0.
- In DRIVE: acender_coluna = ~(7'b1000000 >> col), and linhas = ROM[msg_ativa][(offset+col) mod 16].
- ch1/ch0 pass through a 2-flop synchronizer. The synchronized value commits to msg_ativa only on the frame-boundary edge. A commit that changes the message sets offset=0 and the frame counter to 0.
- Scrolling: a frame counter increments on each frame boundary while scroll_en=1. On the boundary where it equals SCROLL_FRAMES-1, offset=(offset+1) mod 16 (15→0 wraps) and the counter clears. While scroll_en=0, offset holds and the counter holds at 0.
- Simultaneous message change and scroll step on one boundary: the message change wins, giving offset=0 and counter=0.
- Unchanged switch value at a boundary: no effect on offset.
- Reset (asynchronous, any time, including mid-frame) sets:
  - pre=0, col=0, offset=0, frame counter=0, msg_ativa=0, synchronizers=0;
  - acender_coluna=7'h7F, linhas=0, frame_start=0.

## Timing
- All outputs are registered and change only on clk rising edges, except the asynchronous reset assertion.
- First edge after rst_n deasserts: pre=1, DRIVE col 0, acender_coluna=7'b0111111, frame_start=1 for one cycle.
- Column period is CLK_DIV cycles: 1 BLANK followed by CLK_DIV-1 DRIVE. Frame period is 7·CLK_DIV cycles.
- Switch latency:
  - 2 cycles of synchronization;
  - then the next frame boundary;
  - msg_ativa changes on the boundary edge, during col-0 BLANK.
  - Worst case is about 7·CLK_DIV+2 cycles.
- A new offset also takes effect on the boundary edge, so a frame is never split between two offsets or two messages.

## Structure
- Package matrix_pkg holds:
  - constants NCOLS=7, NROWS=5, MSG_LEN=16;
  - the 4×16×5-bit pattern ROM as a constant array;
  - function msg_col(msg, idx) returning 5 bits.
- Sub-module tick_gen (the prescaler) outputs the pre==0 BLANK flag and the wrap strobe; it is parameterized by CLK_DIV.
- Column, offset, frame-counter and message logic live in matrix_scan_ctrl itself.

## Test plan
All scenarios use CLK_DIV=4 and SCROLL_FRAMES=2; linhas is checked against msg_col.
- Reset hold then release:
  - during reset: acender_coluna=7'h7F, linhas=0, msg_ativa=0;
  - next edge: acender_coluna=7'b0111111, frame_start=1 for exactly one cycle.
- Free run, scroll_en=0:
  - per column: 1 cycle of 7'h7F, then 3 cycles of the strobe;
  - strobe sequence 0111111, 1011111, …, 1111110, repeating;
  - frame_start every 28 cycles;
  - linhas = msg_col(0, col).
- {ch1,ch0}=2'b10 applied during col 3: msg_ativa stays 0 through col 6, becomes 2 at col-0 BLANK, and col-0 linhas = msg_col(2,0).
- scroll_en=1:
  - offset advances 1 every 2 frames, so col-0 linhas = msg_col(0, offset);
  - after 32 frames offset wraps 15→0.
- Switch change committing on the same boundary as a scroll step: offset=0, and the next scroll step comes 2 frames later.
- rst_n pulsed low for 1 cycle at col 4: outputs go to reset values immediately, and on release the sequence restarts at col 0 with frame_start.

Source files
------------

// File: rtl/matrix_pkg.sv
`default_nettype none
// ============================================================================
// Module      : matrix_pkg
// Description : Shared constants, scan state encoding and the 4-message
//               pattern ROM for the 5x7 LED dot-matrix scan controller.
// Revision    : 1.0 - initial release
// ============================================================================
package matrix_pkg;

    localparam int NCOLS   = 7;
    localparam int NROWS   = 5;
    localparam int MSG_LEN = 16;
    localparam int NMSGS   = 4;

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } scan_state_t;

    // Indexed [message][column]; bit 0 of each entry is the top row.
    localparam logic [NROWS-1:0] MSG_ROM [NMSGS][MSG_LEN] = '{
        '{5'h01, 5'h02, 5'h04, 5'h08, 5'h10, 5'h03, 5'h06, 5'h0C,
          5'h18, 5'h05, 5'h0A, 5'h14, 5'h07, 5'h0E, 5'h1C, 5'h1F},
        '{5'h1E, 5'h1D, 5'h1B, 5'h17, 5'h0F, 5'h11, 5'h09, 5'h12,
          5'h15, 5'h0B, 5'h16, 5'h0D, 5'h1A, 5'h13, 5'h19, 5'h00},
        '{5'h11, 5'h0A, 5'h04, 5'h0A, 5'h11, 5'h00, 5'h1F, 5'h04,
          5'h04, 5'h1F, 5'h00, 5'h0E, 5'h11, 5'h11, 5'h0E, 5'h00},
        '{5'h15, 5'h0A, 5'h15, 5'h0A, 5'h1C, 5'h07, 5'h1C, 5'h07,
          5'h18, 5'h03, 5'h18, 5'h03, 5'h1E, 5'h01, 5'h1E, 5'h01}
    };

    function automatic logic [NROWS-1:0] msg_col(input logic [1:0] msg,
                                                  input logic [3:0] idx);
        return MSG_ROM[msg][idx];
    endfunction

endpackage
`default_nettype wire

// File: rtl/matrix_scan_ctrl_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : tick_gen
// Description : Column-period prescaler. Flags are look-ahead: they describe
//               the prescaler value that the next clock edge will load.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_gen #(
    parameter int CLK_DIV = 50000
) (
    input  logic clk,
    input  logic rst_n,
    output logic blank_nxt,
    output logic first_nxt,
    output logic wrap
);

    localparam int PRE_W = $clog2(CLK_DIV);

    logic [PRE_W-1:0] r_pre;
    logic [PRE_W-1:0] w_pre_nxt;

    assign wrap      = (r_pre == PRE_W'(CLK_DIV - 1));
    assign w_pre_nxt = wrap ? '0 : (r_pre + PRE_W'(1));
    assign blank_nxt = (w_pre_nxt == '0);
    assign first_nxt = (w_pre_nxt == PRE_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre <= '0;
        end else begin
            r_pre <= w_pre_nxt;
        end
    end

endmodule
`default_nettype wire

// File: rtl/matrix_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : matrix_scan_ctrl
// Description : 5x7 LED matrix column scanner with anti-ghost blanking,
//               message select and frame-aligned window scrolling.
// Revision    : 1.0 - initial release
// ============================================================================
module matrix_scan_ctrl
    import matrix_pkg::*;
#(
    parameter int CLK_DIV       = 50000,
    parameter int SCROLL_FRAMES = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ch1,
    input  logic       ch0,
    input  logic       scroll_en,
    output logic [6:0] acender_coluna,
    output logic [4:0] linhas,
    output logic       frame_start,
    output logic [1:0] msg_ativa
);

    localparam int CNT_W = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;

    localparam logic [6:0] c_cols_off   = 7'h7F;
    localparam logic [6:0] c_col0_onehot = 7'b1000000;

    logic             w_blank_nxt;
    logic             w_first_nxt;
    logic             w_wrap;

    logic [1:0]       r_sync1;
    logic [1:0]       r_sync2;
    logic [2:0]       r_col;
    logic [3:0]       r_offset;
    logic [CNT_W-1:0] r_frame_cnt;

    logic             w_boundary;
    logic             w_msg_change;
    logic [2:0]       w_col_nxt;
    logic [1:0]       w_msg_nxt;
    logic [3:0]       w_offset_nxt;
    logic [3:0]       w_rom_idx;
    logic [CNT_W-1:0] w_frame_cnt_nxt;
    scan_state_t      w_state_nxt;

    tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .blank_nxt (w_blank_nxt),
        .first_nxt (w_first_nxt),
        .wrap      (w_wrap)
    );

    // Everything is computed for the state after the coming edge so that the
    // registered outputs line up with the new column/message/offset.
    always_comb begin
        w_boundary      = w_wrap && (r_col == 3'(NCOLS - 1));
        w_col_nxt       = r_col;
        if (w_wrap) begin
            w_col_nxt = w_boundary ? 3'd0 : (r_col + 3'd1);
        end

        w_msg_nxt       = w_boundary ? r_sync2 : msg_ativa;
        w_msg_change    = w_boundary && (r_sync2 != msg_ativa);

        w_offset_nxt    = r_offset;
        w_frame_cnt_nxt = r_frame_cnt;
        if (w_msg_change) begin
            w_offset_nxt    = 4'd0;
            w_frame_cnt_nxt = '0;
        end else if (!scroll_en) begin
            w_frame_cnt_nxt = '0;
        end else if (w_boundary) begin
            if (r_frame_cnt == CNT_W'(SCROLL_FRAMES - 1)) begin
                w_offset_nxt    = r_offset + 4'd1;
                w_frame_cnt_nxt = '0;
            end else begin
                w_frame_cnt_nxt = r_frame_cnt + CNT_W'(1);
            end
        end

        w_rom_idx   = w_offset_nxt + {1'b0, w_col_nxt};
        w_state_nxt = w_blank_nxt ? ST_BLANK : ST_DRIVE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1        <= 2'b00;
            r_sync2        <= 2'b00;
            r_col          <= 3'd0;
            r_offset       <= 4'd0;
            r_frame_cnt    <= '0;
            msg_ativa      <= 2'b00;
            frame_start    <= 1'b0;
            acender_coluna <= c_cols_off;
            linhas         <= 5'b00000;
        end else begin
            r_sync1     <= {ch1, ch0};
            r_sync2     <= r_sync1;
            r_col       <= w_col_nxt;
            r_offset    <= w_offset_nxt;
            r_frame_cnt <= w_frame_cnt_nxt;
            msg_ativa   <= w_msg_nxt;
            frame_start <= w_first_nxt && (w_col_nxt == 3'd0);
            case (w_state_nxt)
                ST_BLANK: begin
                    acender_coluna <= c_cols_off;
                    linhas         <= 5'b00000;
                end
                ST_DRIVE: begin
                    acender_coluna <= ~(c_col0_onehot >> w_col_nxt);
                    linhas         <= msg_col(w_msg_nxt, w_rom_idx);
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_matrix_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_matrix_scan_ctrl
// Description : Directed self-checking bench for matrix_scan_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_matrix_scan_ctrl;

    localparam int CLK_DIV       = 4;
    localparam int SCROLL_FRAMES = 2;
    localparam int FRAME         = 7 * CLK_DIV;

    localparam logic [6:0] C_STROBE [7] = '{
        7'b0111111, 7'b1011111, 7'b1101111, 7'b1110111,
        7'b1111011, 7'b1111101, 7'b1111110
    };

    localparam logic [4:0] C_ROM [4][16] = '{
        '{5'h01, 5'h02, 5'h04, 5'h08, 5'h10, 5'h03, 5'h06, 5'h0C,
          5'h18, 5'h05, 5'h0A, 5'h14, 5'h07, 5'h0E, 5'h1C, 5'h1F},
        '{5'h1E, 5'h1D, 5'h1B, 5'h17, 5'h0F, 5'h11, 5'h09, 5'h12,
          5'h15, 5'h0B, 5'h16, 5'h0D, 5'h1A, 5'h13, 5'h19, 5'h00},
        '{5'h11, 5'h0A, 5'h04, 5'h0A, 5'h11, 5'h00, 5'h1F, 5'h04,
          5'h04, 5'h1F, 5'h00, 5'h0E, 5'h11, 5'h11, 5'h0E, 5'h00},
        '{5'h15, 5'h0A, 5'h15, 5'h0A, 5'h1C, 5'h07, 5'h1C, 5'h07,
          5'h18, 5'h03, 5'h18, 5'h03, 5'h1E, 5'h01, 5'h1E, 5'h01}
    };

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       ch1       = 1'b0;
    logic       ch0       = 1'b0;
    logic       scroll_en = 1'b0;
    logic [6:0] acender_coluna;
    logic [4:0] linhas;
    logic       frame_start;
    logic [1:0] msg_ativa;

    int n_checks = 0;
    int n_pass   = 0;
    int t        = 0;
    int exp_msg  = 0;
    int exp_off  = 0;

    matrix_scan_ctrl #(
        .CLK_DIV       (CLK_DIV),
        .SCROLL_FRAMES (SCROLL_FRAMES)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ch1            (ch1),
        .ch0            (ch0),
        .scroll_en      (scroll_en),
        .acender_coluna (acender_coluna),
        .linhas         (linhas),
        .frame_start    (frame_start),
        .msg_ativa      (msg_ativa)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp_v);
        n_checks++;
        if (obs === exp_v) begin
            n_pass++;
        end else begin
            $display("FAIL %s @t=%0d: got 0x%0h, expected 0x%0h",
                     tag, t, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        t++;
    endtask

    // t counts edges since reset release; phase within the frame gives
    // the column and prescaler position directly.
    task automatic check_cycle();
        int         ph;
        int         pre;
        int         col;
        logic [6:0] e_str;
        logic [4:0] e_lin;
        ph  = t % FRAME;
        pre = ph % CLK_DIV;
        col = ph / CLK_DIV;
        if (pre == 0) begin
            e_str = 7'h7F;
            e_lin = 5'h00;
        end else begin
            e_str = C_STROBE[col];
            e_lin = C_ROM[exp_msg][(exp_off + col) % 16];
        end
        check("strobe",      32'(acender_coluna), 32'(e_str));
        check("linhas",      32'(linhas),         32'(e_lin));
        check("frame_start", 32'(frame_start),    (ph == 1) ? 32'd1 : 32'd0);
        check("msg_ativa",   32'(msg_ativa),      32'(exp_msg));
    endtask

    task automatic run_to(input int ph);
        do begin
            step();
            check_cycle();
        end while ((t % FRAME) != ph);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_strobe"}, 32'(acender_coluna), 32'h7F);
        check({tag, "_linhas"}, 32'(linhas),         32'h00);
        check({tag, "_fs"},     32'(frame_start),    32'h0);
        check({tag, "_msg"},    32'(msg_ativa),      32'h0);
    endtask

    initial begin
        // Reset hold, then release away from the clock edge
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst_hold");
        rst_n = 1'b1;
        t     = 0;
        step();
        check("first_strobe", 32'(acender_coluna), 32'b0111111);
        check("first_fs",     32'(frame_start),    32'd1);
        step();
        check("fs_one_cycle", 32'(frame_start),    32'd0);

        // Free run, message 0, no scrolling
        run_to(FRAME - 1);
        run_to(FRAME - 1);

        // Switch to message 2 during column 3; commits at next boundary
        run_to(13);
        {ch1, ch0} = 2'b10;
        run_to(FRAME - 1);
        exp_msg = 2;
        exp_off = 0;
        run_to(FRAME - 1);

        // Scrolling: one step every 2 frames, wraps after 32 frames
        scroll_en = 1'b1;
        for (int f = 1; f <= 34; f++) begin
            exp_off = (f / 2) % 16;
            run_to(FRAME - 1);
        end

        // Message change lands on a boundary that would also scroll
        exp_off = (35 / 2) % 16;
        run_to(13);
        {ch1, ch0} = 2'b01;
        run_to(FRAME - 1);
        exp_msg = 1;
        exp_off = 0;
        run_to(FRAME - 1);
        run_to(FRAME - 1);
        exp_off = 1;
        run_to(FRAME - 1);

        // Asynchronous reset pulse at column 4
        scroll_en  = 1'b0;
        {ch1, ch0} = 2'b00;
        run_to(17);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_async");
        @(posedge clk);
        #1;
        check_reset_outputs("rst_pulse");
        rst_n   = 1'b1;
        t       = 0;
        exp_msg = 0;
        exp_off = 0;
        run_to(FRAME - 1);
        run_to(FRAME - 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
